// File: rtl/sfp_if.sv
// sfp_if: signed fixed-point value carrier, IW integer bits and QW fraction bits.
interface sfp_if #(
  parameter int IW = 8,
  parameter int QW = 8
) ();
  logic [IW+QW-1:0] val;
  modport in  (input  val);
  modport out (output val);
endinterface

// File: rtl/sfp_div.sv
// sfp_div: sequential signed fixed-point divider, restoring division on magnitudes, one quotient bit per cycle.
// Define SFP_DIV_ROUND_EN to add a guard bit and round half away from zero.
module sfp_div #(
  parameter bit CLIP = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  sfp_if.in    x,
  sfp_if.in    y,
  sfp_if.out   out,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic clipping,
  output logic div_by_zero
);
  localparam int XW = x.IW + x.QW;
  localparam int YW = y.IW + y.QW;
  localparam int W  = out.IW + out.QW;
  localparam int S  = out.QW + y.QW - x.QW;
  localparam int NW = XW + S;
`ifdef SFP_DIV_ROUND_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  localparam int NI  = NW + R;
  localparam int MW  = NI > W ? NI : W;
  localparam int CNW = $clog2(NI + 1);
  generate
    if (S < 0) begin : g_bad_fmt
      $error("sfp_div: out.QW + y.QW must not be smaller than x.QW");
    end
  endgenerate
  typedef enum logic [2:0] {IDLE, ZCHK, DIV, FIX, DONE} state_t;
  state_t state, nxt;
  logic sign, xneg, ovf;
  logic [XW:0] xe, ax;
  logic [YW:0] ye, ay, rem;
  logic [YW+1:0] diff;
  logic [NI-1:0] nq;
  logic [CNW-1:0] cnt;
  logic [MW-1:0] mag;
  logic [W-1:0] res, minv, maxv, wrap;
  assign xe = {x.val[XW-1], x.val};
  assign ye = {y.val[YW-1], y.val};
  // nq shifts numerator bits out of the top while quotient bits enter at the bottom
  assign diff = {rem, nq[NI-1]} - {1'b0, ay};
  assign mag = MW'(nq >> R) + MW'(R != 0 && nq[0]);
  assign minv = {1'b1, {(W-1){1'b0}}};
  assign maxv = ~minv;
  assign ovf = sign ? mag > MW'(minv) : mag > MW'(maxv);
  assign wrap = sign ? -mag[W-1:0] : mag[W-1:0];
  assign out.val = res;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = ZCHK;
      end
      ZCHK: nxt = ay == '0 ? FIX : DIV;
      DIV: if (cnt == '0) nxt = FIX;
      FIX: nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sign <= 1'b0;
      xneg <= 1'b0;
      ax <= '0;
      ay <= '0;
      rem <= '0;
      nq <= '0;
      cnt <= '0;
      res <= '0;
      clipping <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= xe[XW] ^ ye[YW];
          xneg <= xe[XW];
          ax <= xe[XW] ? -xe : xe;
          ay <= ye[YW] ? -ye : ye;
          clipping <= 1'b0;
          div_by_zero <= 1'b0;
        end
        ZCHK: begin
          div_by_zero <= ay == '0;
          rem <= '0;
          nq <= NI'(ax) << (S + R);
          cnt <= CNW'(NI - 1);
        end
        DIV: begin
          rem <= diff[YW+1] ? {rem[YW-1:0], nq[NI-1]} : diff[YW:0];
          nq <= {nq[NI-2:0], ~diff[YW+1]};
          cnt <= cnt - CNW'(1);
        end
        FIX: begin
          res <= div_by_zero ? (ax == '0 ? '0 : (xneg ? minv : maxv)) :
                 (CLIP && ovf) ? (sign ? minv : maxv) : wrap;
          clipping <= !div_by_zero && ovf;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sfp_div.sv
// tb_sfp_div: directed Q8.8 checks of sfp_div, wrap (CLIP=0) and saturate (CLIP=1) instances side by side.
module tb_sfp_div;
`ifdef SFP_DIV_ROUND_EN
  localparam int LAT = 27;
  localparam logic [15:0] TWO_THIRDS = 16'h00AB;
`else
  localparam int LAT = 26;
  localparam logic [15:0] TWO_THIRDS = 16'h00AA;
`endif
  logic clk, rst_n, in_valid, out_ready;
  logic ir0, ir1, ov0, ov1, clip0, clip1, dz0, dz1;
  int checks = 0;
  int errors = 0;
  sfp_if #(.IW(8), .QW(8)) xi ();
  sfp_if #(.IW(8), .QW(8)) yi ();
  sfp_if #(.IW(8), .QW(8)) o0 ();
  sfp_if #(.IW(8), .QW(8)) o1 ();
  sfp_div #(.CLIP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .x(xi), .y(yi), .out(o0),
    .in_valid(in_valid), .in_ready(ir0), .out_valid(ov0), .out_ready(out_ready),
    .clipping(clip0), .div_by_zero(dz0)
  );
  sfp_div #(.CLIP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .x(xi), .y(yi), .out(o1),
    .in_valid(in_valid), .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready),
    .clipping(clip1), .div_by_zero(dz1)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                     input logic [15:0] e0, input logic [15:0] e1,
                     input logic ec, input logic ed, input int lat);
    int n;
    logic busy;
    @(negedge clk);
    xi.val = xv;
    yi.val = yv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    busy = 1'b0;
    while (!ov0 && n < 100) begin
      busy |= ir0 | ir1;
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ov1"}, ov1, 1);
    chk({tag, "_out0"}, o0.val, e0);
    chk({tag, "_out1"}, o1.val, e1);
    chk({tag, "_clip0"}, clip0, ec);
    chk({tag, "_clip1"}, clip1, ec);
    chk({tag, "_dz0"}, dz0, ed);
    chk({tag, "_dz1"}, dz1, ed);
  endtask
  task automatic rel();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("rel_ov", ov0 | ov1, 0);
    chk("rel_ir", ir0 & ir1, 1);
  endtask
  initial begin
    logic stable;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    xi.val = '0;
    yi.val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir", {ir0, ir1}, 2'b11);
    chk("rst_ov", {ov0, ov1}, 2'b00);
    chk("rst_out", {o0.val, o1.val}, 32'h0);
    chk("rst_flags", {clip0, clip1, dz0, dz1}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    run("p3d2", 16'h0300, 16'h0200, 16'h0180, 16'h0180, 1'b0, 1'b0, LAT); rel();
    run("m1d4", 16'hFF00, 16'h0400, 16'hFFC0, 16'hFFC0, 1'b0, 1'b0, LAT); rel();
    run("m1dm4", 16'hFF00, 16'hFC00, 16'h0040, 16'h0040, 1'b0, 1'b0, LAT); rel();
    run("p2d3", 16'h0200, 16'h0300, TWO_THIRDS, TWO_THIRDS, 1'b0, 1'b0, LAT); rel();
    run("ovf100", 16'h6400, 16'h0080, 16'hC800, 16'h7FFF, 1'b1, 1'b0, LAT); rel();
    run("ovfmin", 16'h8000, 16'hFF00, 16'h8000, 16'h7FFF, 1'b1, 1'b0, LAT); rel();
    run("dz_pos", 16'h0100, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 2); rel();
    run("dz_neg", 16'hFF00, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1, 2); rel();
    run("dz_zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 2); rel();
    run("bp", 16'h0300, 16'h0200, 16'h0180, 16'h0180, 1'b0, 1'b0, LAT);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 stable &= (o0.val === 16'h0180) && (o1.val === 16'h0180) && ov0 && ov1 &&
                   !ir0 && !ir1 && !clip0 && !dz0;
    end
    chk("bp_stable", stable, 1);
    rel();
    @(negedge clk);
    xi.val = 16'h0300;
    yi.val = 16'h0200;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ov", {ov0, ov1}, 2'b00);
    chk("abort_ir", {ir0, ir1}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", 16'h0300, 16'h0200, 16'h0180, 16'h0180, 1'b0, 1'b0, LAT); rel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
